// File: rtl/msf_symbol_sampler.sv
// MSF carrier sampler: synchronises the demodulated input, locks to each second's on->off
// edge, majority-votes five 100 ms windows and emits one decoded symbol per second.
module msf_symbol_sampler #(
  parameter int SLOT_CYCLES      = 100,
  parameter int VOTE_MIN         = 6,
  parameter int SYNC_STAGES      = 2,
  parameter int DATA_ACTIVE_HIGH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_i,
  output logic bit_a_o,
  output logic bit_b_o,
  output logic minute_o,
  output logic valid_o,
  output logic error_o,
  output logic busy_o
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_MID  = CW'(SLOT_CYCLES / 2);
  localparam logic          OFF_LVL   = (DATA_ACTIVE_HIGH != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_W0, S_W1, S_W2, S_W3, S_W4, S_GUARD
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CW-1:0]          slot_q, slot_d;
  logic [5:0]             idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             win_q, win_d;
  logic                   valid_q, valid_d, error_q, error_d;
  logic                   a_q, a_d, b_q, b_d, m_q, m_d;

  logic       off, edge_det, in_win, sample, slot_end, win_end, guard_end, win_off, minute;
  logic [3:0] cnt_now;

  // Chain and edge history start at the off level so a held-off input is never an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{OFF_LVL}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_i};
      prev_q <= off;
    end
  end

  assign off       = (sync_q[SYNC_STAGES-1] == OFF_LVL);
  assign edge_det  = off & ~prev_q;
  assign in_win    = (state_q == S_W0) || (state_q == S_W1) || (state_q == S_W2) ||
                     (state_q == S_W3) || (state_q == S_W4);
  assign sample    = in_win && (slot_q == SLOT_MID) && off;
  assign cnt_now   = cnt_q + {3'b000, sample};
  assign win_off   = (cnt_now >= 4'(VOTE_MIN));
  assign slot_end  = (slot_q == SLOT_LAST);
  assign win_end   = slot_end && (idx_q == 6'd9);
  assign guard_end = slot_end && (idx_q == 6'd39);
  assign minute    = win_q[0] & win_q[1] & win_q[2] & win_off;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_end ? '0 : slot_q + CW'(1);
    idx_d   = slot_end ? idx_q + 6'd1 : idx_q;
    cnt_d   = cnt_now;
    win_d   = win_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    case (state_q)
      S_IDLE: begin
        slot_d = '0;
        idx_d  = '0;
        cnt_d  = '0;
        if (edge_det) begin
          state_d = S_W0;
          slot_d  = CW'(1);  // edge cycle itself is slot position 0
        end
      end
      S_W0, S_W1, S_W2, S_W3, S_W4: begin
        if (win_end) begin
          idx_d = '0;
          cnt_d = '0;
          case (state_q)
            S_W0: begin
              if (win_off) state_d = S_W1;
              else begin
                state_d = S_IDLE;
                error_d = 1'b1;
              end
            end
            S_W1: begin win_d[0] = win_off; state_d = S_W2; end
            S_W2: begin win_d[1] = win_off; state_d = S_W3; end
            S_W3: begin win_d[2] = win_off; state_d = S_W4; end
            default: begin
              valid_d = 1'b1;
              m_d     = minute;
              a_d     = minute ? 1'b0 : win_q[0];
              b_d     = minute ? 1'b0 : win_q[1];
              state_d = S_GUARD;
            end
          endcase
        end
      end
      S_GUARD: begin
        cnt_d = '0;
        if (guard_end) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      error_q <= error_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
    end
  end

  assign bit_a_o  = a_q;
  assign bit_b_o  = b_q;
  assign minute_o = m_q;
  assign valid_o  = valid_q;
  assign error_o  = error_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_msf_symbol_sampler.sv
// Directed bench for msf_symbol_sampler with 4-cycle slots; pin edges land at t=-2 so the
// detected edge E is two cycles after each drive.
module tb_msf_symbol_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data = 1'b0;
  logic bit_a, bit_b, minute, valid, error, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0, n_error = 0;
  int last_valid_cyc = -1, last_error_cyc = -1;
  int cap_a = 0, cap_b = 0, cap_m = 0;
  int t0, t1, nv0, ne0;

  msf_symbol_sampler #(
    .SLOT_CYCLES(4), .VOTE_MIN(6), .SYNC_STAGES(2), .DATA_ACTIVE_HIGH(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data),
    .bit_a_o(bit_a), .bit_b_o(bit_b), .minute_o(minute),
    .valid_o(valid), .error_o(error), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      cap_a = int'(bit_a);
      cap_b = int'(bit_b);
      cap_m = int'(minute);
    end
    if (error) begin
      n_error++;
      last_error_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    data = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expect_symbol(input string tag, input int ts, input int nv,
                               input int a, input int b, input int m);
    wait_until(ts + 2 + 370);
    chk({tag, "_count"}, n_valid - nv, 1);
    chk({tag, "_vcyc"}, last_valid_cyc, ts + 202);
    chk({tag, "_a"}, cap_a, a);
    chk({tag, "_b"}, cap_b, b);
    chk({tag, "_min"}, cap_m, m);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_a", int'(bit_a), 0);
    chk("rst_b", int'(bit_b), 0);
    chk("rst_min", int'(minute), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 100 ms off, plus busy boundary at end of guard
    t0 = cyc; nv0 = n_valid;
    hold(1'b1, 40); data = 1'b0;
    wait_until(t0 + 2 + 359);
    chk("s100_busy_359", int'(busy), 1);
    wait_until(t0 + 2 + 360);
    chk("s100_busy_360", int'(busy), 0);
    expect_symbol("s100", t0, nv0, 0, 0, 0);

    t0 = cyc; nv0 = n_valid;
    hold(1'b1, 80); data = 1'b0;
    expect_symbol("s200", t0, nv0, 1, 0, 0);

    t0 = cyc; nv0 = n_valid;
    hold(1'b1, 120); data = 1'b0;
    expect_symbol("s300", t0, nv0, 1, 1, 0);

    t0 = cyc; nv0 = n_valid;
    hold(1'b1, 40); hold(1'b0, 40); hold(1'b1, 40); data = 1'b0;
    expect_symbol("s_b_only", t0, nv0, 0, 1, 0);

    t0 = cyc; nv0 = n_valid;
    hold(1'b1, 200); data = 1'b0;
    expect_symbol("s_minute", t0, nv0, 0, 0, 1);

    // 20 ms glitch rejected, then a normal 100 ms symbol
    t0 = cyc; nv0 = n_valid; ne0 = n_error;
    hold(1'b1, 8); data = 1'b0;
    wait_until(t0 + 2 + 41);
    chk("glitch_ecount", n_error - ne0, 1);
    chk("glitch_ecyc", last_error_cyc, t0 + 42);
    chk("glitch_busy", int'(busy), 0);
    wait_until(t0 + 100);
    chk("glitch_novalid", n_valid - nv0, 0);
    t0 = cyc; nv0 = n_valid;
    hold(1'b1, 40); data = 1'b0;
    expect_symbol("after_glitch", t0, nv0, 0, 0, 0);

    // extra pulse at 600 ms inside guard, then a 200 ms pulse with 3 flipped samples
    t0 = cyc; nv0 = n_valid; ne0 = n_error;
    hold(1'b1, 40); data = 1'b0;
    wait_until(t0 + 240);
    hold(1'b1, 40); data = 1'b0;
    wait_until(t0 + 400);
    chk("guard_vcount", n_valid - nv0, 1);
    chk("guard_ecount", n_error - ne0, 0);
    chk("guard_a", cap_a, 0);
    t1 = cyc; nv0 = n_valid;
    hold(1'b1, 42); hold(1'b0, 12); hold(1'b1, 26); data = 1'b0;
    expect_symbol("vote", t1, nv0, 1, 0, 0);
    chk("vote_ecount", n_error - ne0, 0);

    // reset mid-symbol with data held off
    t0 = cyc; nv0 = n_valid; ne0 = n_error;
    data = 1'b1;
    wait_until(t0 + 100);
    chk("mid_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_a", int'(bit_a), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_until(t0 + 500);
    chk("rst_hold_valid", n_valid - nv0, 0);
    chk("rst_hold_error", n_error - ne0, 0);
    chk("rst_hold_busy", int'(busy), 0);
    hold(1'b0, 20);
    t0 = cyc; nv0 = n_valid;
    hold(1'b1, 80); data = 1'b0;
    expect_symbol("post_rst", t0, nv0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
